// File: rtl/user_module_seq_mac.sv
// Sequential shift-and-add multiply/accumulate unit: one partial product per clock
// over W cycles, with a sticky overflow flag and a paged 6-bit accumulator view.
module user_module_seq_mac #(
   parameter int W     = 4,
   parameter int ACC_W = 12
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   typedef enum logic {IDLE, RUN} state_e;
   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_LOAD = 2'b01,
      CMD_MAC  = 2'b10,
      CMD_MUL  = 2'b11
   } cmd_e;

   logic       clk;
   logic       rst;
   cmd_e       cmd;
   logic [3:0] d;

   assign clk = io_in[0];
   assign rst = io_in[1];
   assign cmd = cmd_e'(io_in[3:2]);
   assign d   = io_in[7:4];

   state_e           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic             b_bit;
   logic [ACC_W-1:0] addend;
   logic [ACC_W:0]   sum;

   // Extra top bit of sum captures the carry out of the accumulator MSB.
   assign b_bit  = |(b_q & (W'(1) << cnt_q));
   assign addend = {{(ACC_W-W){1'b0}}, a_q} << cnt_q;
   assign sum    = {1'b0, acc_q} + {1'b0, addend};

   // NOTE: every next-state signal gets a hold default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            unique case (cmd)
               CMD_LOAD: a_d = d[W-1:0];
               CMD_MAC: begin
                  b_d     = d[W-1:0];
                  cnt_d   = '0;
                  state_d = RUN;
               end
               CMD_MUL: begin
                  b_d     = d[W-1:0];
                  cnt_d   = '0;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = RUN;
               end
               default: ;
            endcase
         end
         RUN: begin
            // Commands are ignored here; the last step lands together with the return to IDLE.
            if (b_bit) begin
               acc_d = sum[ACC_W-1:0];
               if (sum[ACC_W]) ovf_d = 1'b1;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(W-1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   logic [11:0] acc_ext;
   logic        page;

   always_comb begin
      acc_ext              = '0;
      acc_ext[ACC_W-1:0]   = acc_q;
      page                 = (cmd == CMD_NOP) && d[0];
      io_out[7]            = (state_q == RUN);
      io_out[6]            = ovf_q;
      io_out[5:0]          = page ? acc_ext[11:6] : acc_ext[5:0];
   end

endmodule

// File: tb/tb_user_module_seq_mac.sv
// Bench for user_module_seq_mac: directed vector table, overflow sequence,
// then random traffic scored against a command-level arithmetic model.
module tb_user_module_seq_mac;

   localparam int W     = 4;
   localparam int ACC_W = 12;
   localparam int MODV  = 1 << ACC_W;

   logic       clk = 1'b0;
   logic       rst_r = 1'b0;
   logic [1:0] cmd_r = 2'b00;
   logic [3:0] d_r = 4'h0;
   logic [7:0] io_in;
   logic [7:0] io_out;

   assign io_in = {d_r, cmd_r, rst_r, clk};

   user_module_seq_mac #(.W(W), .ACC_W(ACC_W)) dut (
      .io_in (io_in),
      .io_out(io_out)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Command-level model: a MAC/MUL result is A*B added in one step; partial sums are not modelled.
   int m_a, m_acc, m_ovf, m_busy_left, m_pend_acc, m_pend_ovf;

   task automatic model_step(input logic r, input logic [1:0] c, input logic [3:0] dd);
      int tot;
      if (r) begin
         m_a = 0; m_acc = 0; m_ovf = 0; m_busy_left = 0;
      end else if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            m_acc = m_pend_acc;
            m_ovf = m_pend_ovf;
         end
      end else if (c == 2'b01) begin
         m_a = int'(dd) % (1 << W);
      end else if (c != 2'b00) begin
         tot         = ((c == 2'b11) ? 0 : m_acc) + m_a * (int'(dd) % (1 << W));
         m_pend_acc  = tot % MODV;
         m_pend_ovf  = ((c == 2'b10) && (m_ovf != 0)) || (tot >= MODV) ? 1 : 0;
         m_busy_left = W;
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp,
                        input logic [7:0] mask);
      checks++;
      if (((act ^ exp) & mask) != 8'h00) begin
         failures++;
         $display("FAIL %s: io_out=%02h expected=%02h mask=%02h at %0t", name, act, exp, mask, $time);
      end
   endtask

   task automatic do_cycle(input logic r, input logic [1:0] c, input logic [3:0] dd,
                           input logic use_model, input logic [7:0] exp_t,
                           input logic [7:0] mask_t, input string name);
      logic [7:0] e, m;
      int         win;
      @(negedge clk);
      rst_r = r; cmd_r = c; d_r = dd;
      #1;
      if (use_model) begin
         if (m_busy_left > 0) begin
            e = 8'h80; m = 8'h80;
         end else begin
            win = ((c == 2'b00) && dd[0]) ? (m_acc >> 6) & 63 : m_acc & 63;
            e   = {1'b0, m_ovf[0], 6'(win)};
            m   = 8'hFF;
         end
      end else begin
         e = exp_t; m = mask_t;
      end
      if (m != 8'h00) check(name, io_out, e, m);
      @(posedge clk);
      model_step(r, c, dd);
   endtask

   // Issue a command, then expect busy for exactly W cycles.
   task automatic run_cmd(input logic [1:0] c, input logic [3:0] dd, input string name);
      do_cycle(1'b0, c, dd, 1'b0, 8'h00, 8'h00, name);
      for (int i = 0; i < W; i++) do_cycle(1'b0, 2'b00, 4'h0, 1'b0, 8'h80, 8'h80, name);
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] cmd;
      logic [3:0] d;
      logic [7:0] exp;
      logic [7:0] mask;
      string      name;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [1:0] c, input logic [3:0] dd,
                      input logic [7:0] e, input logic [7:0] m, input string n);
      vec_t v;
      v.rst = r; v.cmd = c; v.d = dd; v.exp = e; v.mask = m; v.name = n;
      tbl.push_back(v);
   endtask

   task automatic add_busy(input int n, input string name);
      for (int i = 0; i < n; i++) add(1'b0, 2'b00, 4'h0, 8'h80, 8'h80, name);
   endtask

   initial begin
      m_a = 0; m_acc = 0; m_ovf = 0; m_busy_left = 0; m_pend_acc = 0; m_pend_ovf = 0;

      add(1'b1, 2'b00, 4'h0, 8'h00, 8'h00, "reset");
      add(1'b0, 2'b00, 4'h0, 8'h00, 8'hFF, "after_reset");
      add(1'b0, 2'b00, 4'h0, 8'h00, 8'hFF, "hold0");
      add(1'b0, 2'b00, 4'h1, 8'h00, 8'hFF, "hold1");
      add(1'b0, 2'b00, 4'h0, 8'h00, 8'hFF, "hold2");
      add(1'b0, 2'b01, 4'h5, 8'h00, 8'hFF, "load5");
      add(1'b0, 2'b11, 4'h3, 8'h00, 8'hFF, "mul3");
      add_busy(4, "mul3_busy");
      add(1'b0, 2'b00, 4'h0, 8'h0F, 8'hFF, "mul3_p0");
      add(1'b0, 2'b00, 4'h1, 8'h00, 8'hFF, "mul3_p1");
      add(1'b0, 2'b01, 4'hF, 8'h0F, 8'hFF, "load15");
      add(1'b0, 2'b11, 4'hF, 8'h0F, 8'hFF, "mul15");
      add_busy(4, "mul15_busy");
      add(1'b0, 2'b10, 4'hF, 8'h21, 8'hFF, "b2b_mac15");
      add_busy(4, "mac15_busy");
      add(1'b0, 2'b00, 4'h0, 8'h02, 8'hFF, "acc450_p0");
      add(1'b0, 2'b00, 4'h1, 8'h07, 8'hFF, "acc450_p1");
      add(1'b0, 2'b11, 4'h1, 8'h02, 8'hFF, "mul1");
      add(1'b0, 2'b01, 4'h9, 8'h80, 8'h80, "load9_ignored");
      add(1'b0, 2'b10, 4'hF, 8'h80, 8'h80, "mac_ignored");
      add_busy(2, "mul1_busy");
      add(1'b0, 2'b00, 4'h0, 8'h0F, 8'hFF, "mul1_result");
      add(1'b0, 2'b11, 4'h1, 8'h0F, 8'hFF, "mul1_again");
      add_busy(4, "mul1_again_busy");
      add(1'b0, 2'b00, 4'h0, 8'h0F, 8'hFF, "a_kept_15");
      add(1'b0, 2'b11, 4'h3, 8'h0F, 8'hFF, "mul3_abort");
      add_busy(1, "run_cycle1");
      add(1'b1, 2'b00, 4'h0, 8'h80, 8'h80, "reset_in_run");
      add(1'b0, 2'b11, 4'h2, 8'h00, 8'hFF, "after_abort");
      add_busy(4, "post_abort_busy");
      add(1'b0, 2'b00, 4'h0, 8'h00, 8'hFF, "post_abort_p0");
      add(1'b0, 2'b00, 4'h1, 8'h00, 8'hFF, "post_abort_p1");

      foreach (tbl[i]) do_cycle(tbl[i].rst, tbl[i].cmd, tbl[i].d, 1'b0,
                                tbl[i].exp, tbl[i].mask, tbl[i].name);

      // Accumulator wrap: 225 + 18*225 = 4275 -> 179 with overflow on the 18th MAC.
      do_cycle(1'b0, 2'b01, 4'hF, 1'b0, 8'h00, 8'h00, "ovf_load15");
      run_cmd(2'b11, 4'hF, "ovf_mul15");
      for (int k = 1; k <= 18; k++) begin
         run_cmd(2'b10, 4'hF, "ovf_mac");
         if (k == 17) begin
            do_cycle(1'b0, 2'b00, 4'h0, 1'b0, 8'h12, 8'hFF, "mac17_p0");
            do_cycle(1'b0, 2'b00, 4'h1, 1'b0, 8'h3F, 8'hFF, "mac17_p1");
         end
      end
      do_cycle(1'b0, 2'b00, 4'h0, 1'b0, 8'h73, 8'hFF, "mac18_wrap_p0");
      do_cycle(1'b0, 2'b00, 4'h1, 1'b0, 8'h42, 8'hFF, "mac18_wrap_p1");
      do_cycle(1'b0, 2'b00, 4'h1, 1'b0, 8'h42, 8'hFF, "ovf_sticky");
      run_cmd(2'b11, 4'h0, "mul0");
      do_cycle(1'b0, 2'b00, 4'h0, 1'b0, 8'h00, 8'hFF, "mul0_p0");
      do_cycle(1'b0, 2'b00, 4'h1, 1'b0, 8'h00, 8'hFF, "mul0_p1");

      for (int i = 0; i < 600; i++) begin
         do_cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 1'b1, 8'h00, 8'h00, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
